// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB refill walker.
//  - tlbConfig field offsets and widths of the 84-bit TLB write word
//  - PTE field positions (PFN[29:6], C[5:3], D[2], V[1], G[0])
//  - walker FSM state encoding
//  - pack_config(): assembles the TLB write word from its fields
package tlb_pkg;

  localparam int TLB_IDX_W = 4;
  localparam int CFG_W     = 84;
  localparam int ASID_W    = 8;
  localparam int VPN2_W    = 19;
  localparam int PFN_W     = 24;

  // tlbConfig layout
  localparam int ASID_LSB  = 76;
  localparam int G_BIT     = 75;
  localparam int VPN2_LSB  = 56;
  localparam int PFN1_LSB  = 32;
  localparam int PFN0_LSB  = 6;
  localparam int IDX_LSB   = 0;

  // PTE layout
  localparam int PTE_PFN_LSB = 6;
  localparam int PTE_D_BIT   = 2;
  localparam int PTE_V_BIT   = 1;
  localparam int PTE_G_BIT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_EVEN = 3'd1,
    ST_RD_ODD  = 3'd2,
    ST_WRITE   = 3'd3,
    ST_FAULT   = 3'd4
  } walk_state_e;

  // D and V of each half sit directly below that half's PFN field.
  function automatic logic [CFG_W-1:0] pack_config(
    input logic [ASID_W-1:0]    asid,
    input logic                 g,
    input logic [VPN2_W-1:0]    vpn2,
    input logic [PFN_W-1:0]     pfn1,
    input logic                 d1,
    input logic                 v1,
    input logic [PFN_W-1:0]     pfn0,
    input logic                 d0,
    input logic                 v0,
    input logic [TLB_IDX_W-1:0] idx
  );
    logic [CFG_W-1:0] cfg;
    cfg                           = '0;
    cfg[ASID_LSB +: ASID_W]       = asid;
    cfg[G_BIT]                    = g;
    cfg[VPN2_LSB +: VPN2_W]       = vpn2;
    cfg[PFN1_LSB +: PFN_W]        = pfn1;
    cfg[PFN1_LSB-1]               = d1;
    cfg[PFN1_LSB-2]               = v1;
    cfg[PFN0_LSB +: PFN_W]        = pfn0;
    cfg[PFN0_LSB-1]               = d0;
    cfg[PFN0_LSB-2]               = v0;
    cfg[IDX_LSB +: TLB_IDX_W]     = idx;
    return cfg;
  endfunction

endpackage

// File: rtl/tlb_random_index.sv
// tlb_random_index: wired-aware decrementing replacement counter.
//  clk      in  system clock
//  rst_n    in  asynchronous active-low reset (counter <- RAND_RST)
//  advance  in  one TLB write was issued; step the counter
//  wired    in  entries below this index are never replaced
//  idx      out replacement slot = max(counter, wired)
module tlb_random_index
  import tlb_pkg::*;
#(
  parameter logic [TLB_IDX_W-1:0] RAND_RST = 4'd15,
  parameter logic [TLB_IDX_W-1:0] RELOAD   = 4'd15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 advance,
  input  logic [TLB_IDX_W-1:0] wired,
  output logic [TLB_IDX_W-1:0] idx
);

  logic [TLB_IDX_W-1:0] random_q;

  // Reload when the decremented value would land at or below wired
  // (compared one bit wider so wired=15 cannot wrap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_q <= RAND_RST;
    end else if (advance) begin
      if ({1'b0, random_q} <= ({1'b0, wired} + 5'd1)) begin
        random_q <= RELOAD;
      end else begin
        random_q <= random_q - 4'd1;
      end
    end
  end

  assign idx = (random_q > wired) ? random_q : wired;

endmodule

// File: rtl/tlb_refill_walker.sv
// tlb_refill_walker: hardware TLB refill engine.
//  On miss_req (IDLE only) reads the even/odd PTE pair at pte_base + (VPN2<<3),
//  packs both into the 84-bit TLB write word and pulses tlbwi into a
//  round-robin slot chosen by tlb_random_index.
//  Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   miss_req/vaddr/asid        walk request from the MMU
//   pte_base                   page-table base (8-byte aligned)
//   wired                      lowest replaceable TLB index
//   abort                      pipeline flush; cancels the walk after the bus read
//   mem_req/mem_addr           bus read request and address
//   mem_ack/mem_err/mem_rdata  bus response
//   tlbConfig/tlbwi            TLB write word and one-cycle write strobe
//   busy/done/fault            walk status
module tlb_refill_walker
  import tlb_pkg::*;
#(
  parameter int                   NENTRY   = 16,
  parameter logic [TLB_IDX_W-1:0] RAND_RST = 4'd15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 miss_req,
  input  logic [31:0]          miss_vaddr,
  input  logic [7:0]           miss_asid,
  input  logic [31:0]          pte_base,
  input  logic [3:0]           wired,
  input  logic                 abort,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  input  logic                 mem_ack,
  input  logic                 mem_err,
  input  logic [31:0]          mem_rdata,
  output logic [CFG_W-1:0]     tlbConfig,
  output logic                 tlbwi,
  output logic                 busy,
  output logic                 done,
  output logic                 fault
);

  localparam logic [TLB_IDX_W-1:0] RELOAD = TLB_IDX_W'(NENTRY - 1);

  walk_state_e          state_q, state_d;
  logic                 abort_q;
  logic                 kill;
  logic                 cfg_load;
  logic [TLB_IDX_W-1:0] idx;

  logic [VPN2_W-1:0]    vpn2_q;
  logic [ASID_W-1:0]    asid_q;
  logic [31:0]          base_q;
  logic [PFN_W-1:0]     pfn0_q;
  logic                 d0_q, v0_q, g0_q;
  logic [31:0]          even_addr;

  // Address bits below the VPN2 field and the PTE cache attribute are not needed.
  logic                 unused_bits;
  assign unused_bits = ^{miss_vaddr[12:0], mem_rdata[31:30], mem_rdata[5:3]};

  tlb_random_index #(
    .RAND_RST (RAND_RST),
    .RELOAD   (RELOAD)
  ) u_random (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (tlbwi),
    .wired   (wired),
    .idx     (idx)
  );

  assign even_addr = base_q + {vpn2_q, 3'b000};
  assign busy      = (state_q != ST_IDLE);
  // A flush seen in the final cycle suppresses the result just like an earlier one.
  assign kill      = abort_q | abort;
  assign cfg_load  = (state_q == ST_RD_ODD) && mem_ack && !mem_err && !kill;

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    tlbwi    = 1'b0;
    done     = 1'b0;
    fault    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_req && !abort) state_d = ST_RD_EVEN;
      end
      ST_RD_EVEN: begin
        mem_req  = 1'b1;
        mem_addr = even_addr;
        if (mem_ack) state_d = mem_err ? ST_FAULT : ST_RD_ODD;
      end
      ST_RD_ODD: begin
        mem_req  = 1'b1;
        mem_addr = even_addr + 32'd4;
        if (mem_ack) state_d = mem_err ? ST_FAULT : ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (!kill) begin
          tlbwi = 1'b1;
          done  = 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
        if (!kill) begin
          done  = 1'b1;
          fault = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and the TLB write word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      abort_q   <= 1'b0;
      tlbConfig <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        abort_q <= 1'b0;
      end else if (abort) begin
        abort_q <= 1'b1;
      end
      // Odd PTE arrives straight from the bus; the word then holds until the next walk.
      if (cfg_load) begin
        tlbConfig <= pack_config(asid_q,
                                 g0_q & mem_rdata[PTE_G_BIT],
                                 vpn2_q,
                                 mem_rdata[PTE_PFN_LSB +: PFN_W],
                                 mem_rdata[PTE_D_BIT],
                                 mem_rdata[PTE_V_BIT],
                                 pfn0_q, d0_q, v0_q, idx);
      end
    end
  end

  // Request capture and even PTE
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && miss_req) begin
      vpn2_q <= miss_vaddr[31:13];
      asid_q <= miss_asid;
      base_q <= pte_base;
    end
    if ((state_q == ST_RD_EVEN) && mem_ack) begin
      pfn0_q <= mem_rdata[PTE_PFN_LSB +: PFN_W];
      d0_q   <= mem_rdata[PTE_D_BIT];
      v0_q   <= mem_rdata[PTE_V_BIT];
      g0_q   <= mem_rdata[PTE_G_BIT];
    end
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
module tb_tlb_refill_walker;

  logic        clk, rst_n, miss_req, abort, mem_ack, mem_err;
  logic [31:0] miss_vaddr, pte_base, mem_rdata, mem_addr;
  logic [7:0]  miss_asid;
  logic [3:0]  wired;
  logic        mem_req, tlbwi, busy, done, fault;
  logic [83:0] tlbConfig;

  int errors = 0;
  int checks = 0;
  int rnd    = 15;   // reference replacement counter

  typedef struct {
    int          n_wi, n_done, n_fault, req_cycles, end_cyc, wr_cyc;
    logic [83:0] cfg;
    logic [31:0] addr0, addr1;
    bit          unstable, timeout;
  } obs_t;

  tlb_refill_walker dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_vaddr(miss_vaddr),
    .miss_asid(miss_asid), .pte_base(pte_base), .wired(wired), .abort(abort),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_err(mem_err),
    .mem_rdata(mem_rdata), .tlbConfig(tlbConfig), .tlbwi(tlbwi), .busy(busy),
    .done(done), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic obs_t blank_obs();
    obs_t b;
    b.n_wi = 0; b.n_done = 0; b.n_fault = 0; b.req_cycles = 0;
    b.end_cyc = 0; b.wr_cyc = 0; b.cfg = '0; b.addr0 = '0; b.addr1 = '0;
    b.unstable = 0; b.timeout = 0;
    return b;
  endfunction

  // Reference model: what a walk should look like, cycle 0 being the request cycle.
  function automatic obs_t model_walk(input logic [31:0] va, input logic [7:0] as,
                                      input logic [31:0] base, input logic [31:0] pe,
                                      input logic [31:0] po, input int we, input int wo,
                                      input bit ee, input bit eo, input int abort_at,
                                      input int wired_v);
    obs_t m;
    int last, ix;
    logic [3:0] idx4;
    m = blank_obs();
    if (abort_at == 0) begin
      m.end_cyc = 1;
      return m;
    end
    m.addr0 = base + ((va >> 13) << 3);
    if (ee) begin
      last = 2 + we;
      m.req_cycles = we + 1;
    end else begin
      last = 3 + we + wo;
      m.req_cycles = we + wo + 2;
      m.addr1 = m.addr0 + 32'd4;
    end
    m.end_cyc = last + 1;
    if (abort_at >= 1 && abort_at <= last) return m;
    if (ee || eo) begin
      m.n_done = 1;
      m.n_fault = 1;
      return m;
    end
    ix = (rnd > wired_v) ? rnd : wired_v;
    idx4 = ix[3:0];
    m.n_wi = 1;
    m.n_done = 1;
    m.wr_cyc = last;
    m.cfg = {as, pe[0] & po[0], va[31:13], po[29:6], po[2], po[1], pe[29:6], pe[2], pe[1], idx4};
    rnd = rnd - 1;
    if (rnd <= wired_v) rnd = 15;
    return m;
  endfunction

  // Issues one request and plays the bus; records what the DUT did.
  task automatic run_walk(input logic [31:0] va, input logic [7:0] as, input logic [31:0] base,
                          input logic [31:0] pe, input logic [31:0] po, input int we, input int wo,
                          input bit ee, input bit eo, input int abort_at, input bit poke,
                          output obs_t o);
    int reads, waitc;
    bit prev_req;
    logic [31:0] prev_addr;
    o = blank_obs();
    reads = 0; waitc = 0; prev_req = 0; prev_addr = '0;
    @(negedge clk);
    miss_req = 1'b1; miss_vaddr = va; miss_asid = as; pte_base = base;
    abort = (abort_at == 0);
    o.timeout = 1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      miss_req = poke && (c == 1);
      abort    = (c == abort_at);
      mem_ack  = 1'b0;
      mem_err  = 1'b0;
      #1;
      if (tlbwi) begin o.n_wi++; o.cfg = tlbConfig; o.wr_cyc = c; end
      if (done)  o.n_done++;
      if (fault) o.n_fault++;
      if (mem_req) begin
        o.req_cycles++;
        if (prev_req && mem_addr !== prev_addr) o.unstable = 1;
        if (waitc == 0) begin
          if (reads == 0) o.addr0 = mem_addr; else o.addr1 = mem_addr;
        end
        if (waitc == ((reads == 0) ? we : wo)) begin
          mem_ack   = 1'b1;
          mem_err   = (reads == 0) ? ee : eo;
          mem_rdata = (reads == 0) ? pe : po;
          reads++;
          waitc = 0;
          prev_req = 0;
        end else begin
          waitc++;
          prev_req = 1;
          prev_addr = mem_addr;
        end
      end
      if (!busy) begin
        o.end_cyc = c;
        o.timeout = 0;
        break;
      end
    end
    miss_req = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rnd = 15;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, tlbwi, busy, done, fault} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, tlbwi, busy, done, fault}); end
    checks++;
    if (tlbConfig !== 84'd0 || mem_addr !== 32'd0)
      begin errors++; $display("FAIL reset_data: cfg=%h addr=%h want 0", tlbConfig, mem_addr); end
    rst_n = 1'b1;
    rnd = 15;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, busy, tlbwi} !== 3'b0)
      begin errors++; $display("FAIL reset_idle: got %b want 000", {mem_req, busy, tlbwi}); end
  endtask

  task automatic test_basic();
    obs_t o, m;
    wired = 4'd0;
    m = model_walk(32'h0040_2000, 8'h3C, 32'h8010_0000, 32'h47, 32'h87, 0, 0, 0, 0, -1, 0);
    run_walk(32'h0040_2000, 8'h3C, 32'h8010_0000, 32'h47, 32'h87, 0, 0, 0, 0, -1, 0, o);
    checks++; if (o.addr0 !== 32'h8010_1008) begin errors++; $display("FAIL basic_addr_even: got %h want 80101008", o.addr0); end
    checks++; if (o.addr1 !== 32'h8010_100C) begin errors++; $display("FAIL basic_addr_odd: got %h want 8010100c", o.addr1); end
    checks++; if (o.n_wi != 1 || o.wr_cyc != 3) begin errors++; $display("FAIL basic_latency: tlbwi count %0d cycle %0d want 1 at 3", o.n_wi, o.wr_cyc); end
    checks++; if (o.cfg[74:56] !== 19'h00201) begin errors++; $display("FAIL basic_vpn2: got %h want 00201", o.cfg[74:56]); end
    checks++; if (o.cfg[29:6] !== 24'h1 || o.cfg[55:32] !== 24'h2) begin errors++; $display("FAIL basic_pfn: pfn0=%h pfn1=%h want 1/2", o.cfg[29:6], o.cfg[55:32]); end
    checks++; if (o.cfg[31:30] !== 2'b11 || o.cfg[5:4] !== 2'b11 || o.cfg[75] !== 1'b1) begin errors++; $display("FAIL basic_dvg: dv1=%b dv0=%b g=%b want 11 11 1", o.cfg[31:30], o.cfg[5:4], o.cfg[75]); end
    checks++; if (o.cfg[3:0] !== 4'd15 || o.cfg[83:76] !== 8'h3C) begin errors++; $display("FAIL basic_idx_asid: idx=%0d asid=%h want 15/3c", o.cfg[3:0], o.cfg[83:76]); end
    checks++; if (o.cfg !== m.cfg || o.end_cyc != 4 || o.unstable) begin errors++; $display("FAIL basic_word: got %h end %0d want %h end 4", o.cfg, o.end_cyc, m.cfg); end
    @(negedge clk);
    checks++; if (tlbConfig !== o.cfg || tlbwi !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_hold: cfg=%h tlbwi=%b want %h 0", tlbConfig, tlbwi, o.cfg); end
  endtask

  task automatic test_back_to_back();
    obs_t o, m;
    int exp12 [8] = '{15, 14, 13, 15, 14, 13, 15, 14};
    do_reset();
    wired = 4'd12;
    for (int i = 0; i < 8; i++) begin
      m = model_walk(32'(i) << 13, 8'(i), 32'h0000_4000, 32'h0000_1047, 32'h0000_2087, 0, 0, 0, 0, -1, 12);
      run_walk(32'(i) << 13, 8'(i), 32'h0000_4000, 32'h0000_1047, 32'h0000_2087, 0, 0, 0, 0, -1, 0, o);
      checks++;
      if (o.n_wi != 1 || int'(o.cfg[3:0]) != exp12[i])
        begin errors++; $display("FAIL b2b_w12[%0d]: idx=%0d writes=%0d want idx %0d", i, o.cfg[3:0], o.n_wi, exp12[i]); end
    end
    wired = 4'd15;
    for (int i = 0; i < 3; i++) begin
      m = model_walk(32'h1000_0000, 8'h11, 32'h0000_4000, 32'h47, 32'h87, 0, 0, 0, 0, -1, 15);
      run_walk(32'h1000_0000, 8'h11, 32'h0000_4000, 32'h47, 32'h87, 0, 0, 0, 0, -1, 0, o);
      checks++;
      if (o.n_wi != 1 || o.cfg[3:0] !== 4'd15)
        begin errors++; $display("FAIL b2b_w15[%0d]: idx=%0d writes=%0d want 15", i, o.cfg[3:0], o.n_wi); end
    end
  endtask

  task automatic test_fault();
    obs_t o, m;
    wired = 4'd0;
    m = model_walk(32'h2222_0000, 8'h01, 32'h0100_0000, 32'h47, 32'h87, 1, 2, 0, 1, -1, 0);
    run_walk(32'h2222_0000, 8'h01, 32'h0100_0000, 32'h47, 32'h87, 1, 2, 0, 1, -1, 0, o);
    checks++;
    if (o.n_done != 1 || o.n_fault != 1 || o.n_wi != 0)
      begin errors++; $display("FAIL fault_odd: done=%0d fault=%0d tlbwi=%0d want 1 1 0", o.n_done, o.n_fault, o.n_wi); end
    checks++;
    if (o.end_cyc != m.end_cyc) begin errors++; $display("FAIL fault_end: got %0d want %0d", o.end_cyc, m.end_cyc); end
    m = model_walk(32'h3333_0000, 8'h02, 32'h0100_0000, 32'h47, 32'h87, 0, 0, 0, 0, -1, 0);
    run_walk(32'h3333_0000, 8'h02, 32'h0100_0000, 32'h47, 32'h87, 0, 0, 0, 0, -1, 0, o);
    checks++;
    if (o.n_wi != 1 || o.cfg[3:0] !== m.cfg[3:0])
      begin errors++; $display("FAIL fault_idx_kept: idx=%0d want %0d", o.cfg[3:0], m.cfg[3:0]); end
  endtask

  task automatic test_abort();
    obs_t o, m;
    wired = 4'd0;
    m = model_walk(32'h4444_0000, 8'h03, 32'h0200_0000, 32'h47, 32'h87, 3, 0, 0, 0, 2, 0);
    run_walk(32'h4444_0000, 8'h03, 32'h0200_0000, 32'h47, 32'h87, 3, 0, 0, 0, 2, 0, o);
    checks++;
    if (o.n_wi != 0 || o.n_done != 0)
      begin errors++; $display("FAIL abort_out: tlbwi=%0d done=%0d want 0 0", o.n_wi, o.n_done); end
    checks++;
    if (o.req_cycles != m.req_cycles || o.addr1 !== m.addr1 || o.end_cyc != m.end_cyc)
      begin errors++; $display("FAIL abort_bus: req=%0d odd=%h end=%0d want %0d %h %0d", o.req_cycles, o.addr1, o.end_cyc, m.req_cycles, m.addr1, m.end_cyc); end
    m = model_walk(32'h5555_0000, 8'h04, 32'h0200_0000, 32'h47, 32'h87, 0, 0, 0, 0, 0, 0);
    run_walk(32'h5555_0000, 8'h04, 32'h0200_0000, 32'h47, 32'h87, 0, 0, 0, 0, 0, 0, o);
    checks++;
    if (o.req_cycles != 0 || o.end_cyc != 1 || o.n_done != 0)
      begin errors++; $display("FAIL abort_idle: req=%0d end=%0d done=%0d want 0 1 0", o.req_cycles, o.end_cyc, o.n_done); end
  endtask

  task automatic test_reset_midwalk();
    obs_t o, m;
    wired = 4'd0;
    m = model_walk(32'h0000_6000, 8'h05, 32'h0010_0000, 32'h47, 32'h87, 0, 0, 0, 0, -1, 0);
    run_walk(32'h0000_6000, 8'h05, 32'h0010_0000, 32'h47, 32'h87, 0, 0, 0, 0, -1, 0, o);
    @(negedge clk);
    miss_req = 1'b1; miss_vaddr = 32'h1234_6000; miss_asid = 8'h06; pte_base = 32'h0010_0000;
    @(negedge clk);
    miss_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h47;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: req=%b busy=%b want 1 1", mem_req, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || tlbwi !== 1'b0)
      begin errors++; $display("FAIL rst_async: req=%b busy=%b tlbwi=%b want 0 0 0", mem_req, busy, tlbwi); end
    @(negedge clk);
    rst_n = 1'b1;
    rnd = 15;
    m = model_walk(32'h0000_8000, 8'h07, 32'h0010_0000, 32'h47, 32'h87, 0, 1, 0, 0, -1, 0);
    run_walk(32'h0000_8000, 8'h07, 32'h0010_0000, 32'h47, 32'h87, 0, 1, 0, 0, -1, 0, o);
    checks++;
    if (o.n_wi != 1 || o.cfg !== m.cfg || o.cfg[3:0] !== 4'd15)
      begin errors++; $display("FAIL rst_after: cfg=%h writes=%0d want %h", o.cfg, o.n_wi, m.cfg); end
  endtask

  task automatic test_global_invalid();
    obs_t o, m;
    wired = 4'd0;
    m = model_walk(32'h7777_E000, 8'h08, 32'h0300_0000, 32'h0000_0141, 32'h0000_0184, 1, 0, 0, 0, -1, 0);
    run_walk(32'h7777_E000, 8'h08, 32'h0300_0000, 32'h0000_0141, 32'h0000_0184, 1, 0, 0, 0, -1, 1, o);
    checks++;
    if (o.n_wi != 1 || o.cfg[75] !== 1'b0 || o.cfg[30] !== 1'b0 || o.cfg[4] !== 1'b0)
      begin errors++; $display("FAIL gv_fields: writes=%0d g=%b v1=%b v0=%b want 1 0 0 0", o.n_wi, o.cfg[75], o.cfg[30], o.cfg[4]); end
    checks++;
    if (o.cfg !== m.cfg || o.end_cyc != m.end_cyc)
      begin errors++; $display("FAIL gv_word: got %h end %0d want %h end %0d", o.cfg, o.end_cyc, m.cfg, m.end_cyc); end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL gv_ignored_req: busy=%b req=%b want 0 0", busy, mem_req); end
  endtask

  task automatic test_random();
    obs_t o, m;
    logic [31:0] va, base, pe, po;
    logic [7:0] as;
    int we, wo, ab, last, wv;
    bit ee, eo;
    for (int i = 0; i < 24; i++) begin
      va = $urandom(); as = 8'($urandom()); base = $urandom() & 32'hFFFF_FFF8;
      pe = $urandom(); po = $urandom();
      we = $urandom_range(0, 3); wo = $urandom_range(0, 3);
      ee = ($urandom_range(0, 7) == 0);
      eo = !ee && ($urandom_range(0, 7) == 0);
      last = ee ? (2 + we) : (3 + we + wo);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, last)) : -1;
      wv = $urandom_range(0, 15);
      @(negedge clk);
      wired = 4'(wv);
      m = model_walk(va, as, base, pe, po, we, wo, ee, eo, ab, wv);
      run_walk(va, as, base, pe, po, we, wo, ee, eo, ab, 0, o);
      checks++;
      if (o.timeout || o.unstable || o.n_wi != m.n_wi || o.n_done != m.n_done || o.n_fault != m.n_fault)
        begin errors++; $display("FAIL rand_ctrl[%0d]: wi=%0d done=%0d fault=%0d to=%0d unst=%0d want %0d %0d %0d", i, o.n_wi, o.n_done, o.n_fault, o.timeout, o.unstable, m.n_wi, m.n_done, m.n_fault); end
      checks++;
      if (o.addr0 !== m.addr0 || o.addr1 !== m.addr1 || o.req_cycles != m.req_cycles || o.end_cyc != m.end_cyc)
        begin errors++; $display("FAIL rand_bus[%0d]: a0=%h a1=%h req=%0d end=%0d want %h %h %0d %0d", i, o.addr0, o.addr1, o.req_cycles, o.end_cyc, m.addr0, m.addr1, m.req_cycles, m.end_cyc); end
      if (m.n_wi == 1) begin
        checks++;
        if (o.cfg !== m.cfg || o.wr_cyc != m.wr_cyc)
          begin errors++; $display("FAIL rand_cfg[%0d]: got %h at %0d want %h at %0d", i, o.cfg, o.wr_cyc, m.cfg, m.wr_cyc); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; miss_req = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
    miss_vaddr = '0; miss_asid = '0; pte_base = '0; mem_rdata = '0; wired = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_fault();
    test_abort();
    test_reset_midwalk();
    test_global_invalid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
